// File: rtl/pwr_wkup_req_gen.sv
// Per-domain wakeup request generator for the RCC Vcore port.
// Turns level wakeup events into held, acknowledged requests with min hold, timeout and D3-first ordering.
module pwr_wkup_req_gen #(
  parameter int unsigned MIN_HOLD = 4,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] wkup_evt,
  input  logic [2:0] rcc_rdy,
  input  logic       d3_run,
  input  logic       err_clr,
  output logic       pwr_d1_wkup,
  output logic       pwr_d2_wkup,
  output logic       pwr_d3_wkup,
  output logic [2:0] busy,
  output logic [2:0] err
);

  localparam int unsigned   NDOM    = 3;
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_D3,
    S_ASSERT,
    S_RELEASE
  } state_e;

  state_e           state_q [NDOM];
  state_e           state_d [NDOM];
  logic [CNT_W-1:0] cnt_q   [NDOM];
  logic [CNT_W-1:0] cnt_d   [NDOM];
  logic [2:0]       wkup_q, wkup_d;
  logic [2:0]       busy_q, busy_d;
  logic [2:0]       err_q, err_d;
  logic             d3_run_q;

  // Next-state, counter and flag logic for all three domains
  always_comb begin
    logic             d3_needed;
    logic [2:0]       req;
    logic [2:0]       err_set;
    logic [CNT_W-1:0] cnt_inc;

    d3_needed = wkup_evt[0] | wkup_evt[1] |
                (state_q[0] == S_WAIT_D3) | (state_q[1] == S_WAIT_D3);
    req       = {wkup_evt[2] | (d3_needed & ~d3_run), wkup_evt[1:0]};
    err_set   = '0;
    cnt_inc   = '0;
    wkup_d    = '0;
    busy_d    = '0;

    for (int i = 0; i < NDOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          cnt_d[i] = '0;
          if (req[i] && !rcc_rdy[i]) begin
            state_d[i] = (i != 2 && !d3_run) ? S_WAIT_D3 : S_ASSERT;
          end
        end
        S_WAIT_D3: begin
          // Registered d3_run gives the extra cycle of settling before D1/D2 wake
          if (d3_run_q) state_d[i] = S_ASSERT;
        end
        S_ASSERT: begin
          cnt_inc  = (cnt_q[i] == TMO) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
          cnt_d[i] = cnt_inc;
          // Ack is tested first so a coincident ack beats the timeout
          if (rcc_rdy[i] && cnt_q[i] >= HOLD_M1) begin
            state_d[i] = S_RELEASE;
          end else if (!rcc_rdy[i] && cnt_inc == TMO) begin
            err_set[i] = 1'b1;
            state_d[i] = S_IDLE;
          end
        end
        S_RELEASE: begin
          if (!wkup_evt[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
      wkup_d[i] = (state_d[i] == S_ASSERT);
      busy_d[i] = (state_d[i] != S_IDLE);
    end

    err_d = (err_q & ~{3{err_clr}}) | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDOM; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      wkup_q   <= '0;
      busy_q   <= '0;
      err_q    <= '0;
      d3_run_q <= 1'b0;
    end else begin
      for (int i = 0; i < NDOM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      wkup_q   <= wkup_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      d3_run_q <= d3_run;
    end
  end

  assign pwr_d1_wkup = wkup_q[0];
  assign pwr_d2_wkup = wkup_q[1];
  assign pwr_d3_wkup = wkup_q[2];
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pwr_wkup_req_gen.sv
// Bench for pwr_wkup_req_gen: directed scenarios, an RCC ack responder,
// and a pulse-width monitor that checks each wkup pulse against a per-domain expected queue.
module tb_pwr_wkup_req_gen;

  logic       clk;
  logic       rst;
  logic [2:0] wkup_evt;
  logic [2:0] rcc_rdy;
  logic [2:0] rdy_man;
  logic [2:0] rdy_auto;
  logic       d3_run;
  logic       err_clr;
  logic       pwr_d1_wkup, pwr_d2_wkup, pwr_d3_wkup;
  logic [2:0] busy;
  logic [2:0] err;
  logic [2:0] wkup_vec;

  int lat  [3];
  int hi_r [3];
  int hi_m [3];
  int exp0 [$];
  int exp1 [$];
  int exp2 [$];
  int n_cmp;
  int n_bad;

  pwr_wkup_req_gen dut (
    .clk        (clk),
    .rst        (rst),
    .wkup_evt   (wkup_evt),
    .rcc_rdy    (rcc_rdy),
    .d3_run     (d3_run),
    .err_clr    (err_clr),
    .pwr_d1_wkup(pwr_d1_wkup),
    .pwr_d2_wkup(pwr_d2_wkup),
    .pwr_d3_wkup(pwr_d3_wkup),
    .busy       (busy),
    .err        (err)
  );

  assign wkup_vec = {pwr_d3_wkup, pwr_d2_wkup, pwr_d1_wkup};
  assign rcc_rdy  = rdy_man | rdy_auto;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RCC model: ready rises during the lat-th high cycle of wkup, held until the event drops
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        hi_r[d]     <= 0;
        rdy_auto[d] <= 1'b0;
      end else if (wkup_vec[d]) begin
        hi_r[d] <= hi_r[d] + 1;
        if (lat[d] != 0 && hi_r[d] + 1 == lat[d]) rdy_auto[d] <= 1'b1;
      end else begin
        hi_r[d] <= 0;
        if (!wkup_evt[d]) rdy_auto[d] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic push_exp(input int d, input int w);
    case (d)
      0:       exp0.push_back(w);
      1:       exp1.push_back(w);
      default: exp2.push_back(w);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_low(input int d, input int budget);
    int n = 0;
    while (wkup_vec[d] && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("wkup%0d_drop_within_budget", d), int'(wkup_vec[d]), 0);
  endtask

  // Monitor: measures each completed wkup pulse and compares with the scoreboard
  task automatic monitor();
    int w;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          hi_m[d] = 0;
        end else if (wkup_vec[d]) begin
          hi_m[d] = hi_m[d] + 1;
        end else if (hi_m[d] != 0) begin
          w = -1;
          case (d)
            0:       if (exp0.size() != 0) w = exp0.pop_front();
            1:       if (exp1.size() != 0) w = exp1.pop_front();
            default: if (exp2.size() != 0) w = exp2.pop_front();
          endcase
          chk($sformatf("wkup%0d_pulse_width", d), hi_m[d], w);
          hi_m[d] = 0;
        end
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    wkup_evt = '0;
    rdy_man  = '0;
    d3_run   = 1'b0;
    err_clr  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      lat[d]  = 0;
      hi_m[d] = 0;
    end
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wkup", int'(wkup_vec), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    rst = 1'b0;
    tick();

    // D3 alone, ack during 10th high cycle
    lat[2] = 10;
    push_exp(2, 10);
    wkup_evt = 3'b100;
    tick();
    chk("d3_alone_rise", int'(pwr_d3_wkup), 1);
    wait_low(2, 40);
    chk("d3_alone_busy_release", int'(busy), 3'b100);
    wkup_evt = 3'b000;
    tick();
    chk("d3_alone_busy_idle", int'(busy), 0);
    chk("d3_alone_err", int'(err), 0);
    lat[2] = 0;

    // Minimum hold on D1 with early ack
    d3_run = 1'b1;
    lat[0] = 1;
    push_exp(0, 4);
    wkup_evt = 3'b001;
    tick();
    chk("minhold_rise", int'(wkup_vec), 3'b001);
    wait_low(0, 20);
    wkup_evt = 3'b000;
    tick();
    chk("minhold_busy_idle", int'(busy), 0);
    lat[0] = 0;

    // D3-before-D1 dependency
    d3_run = 1'b0;
    lat[0] = 2;
    push_exp(2, 4);
    push_exp(0, 4);
    wkup_evt = 3'b001;
    tick();
    chk("dep_d3_first", int'(wkup_vec), 3'b100);
    chk("dep_busy_wait", int'(busy), 3'b101);
    rdy_man[2] = 1'b1;
    repeat (6) tick();
    chk("dep_d1_held_off", int'(pwr_d1_wkup), 0);
    chk("dep_d1_waiting", int'(busy[0]), 1);
    d3_run = 1'b1;
    tick();
    chk("dep_d1_plus1", int'(pwr_d1_wkup), 0);
    tick();
    chk("dep_d1_plus2", int'(pwr_d1_wkup), 1);
    wait_low(0, 20);
    wkup_evt = 3'b000;
    tick();
    rdy_man = '0;
    tick();
    chk("dep_busy_idle", int'(busy), 0);
    chk("dep_err", int'(err), 0);
    lat[0] = 0;

    // Timeout on D2, then clear, then clear coincident with a new timeout
    push_exp(1, 255);
    wkup_evt = 3'b010;
    tick();
    chk("tmo_rise", int'(pwr_d2_wkup), 1);
    wkup_evt = 3'b000;
    wait_low(1, 300);
    chk("tmo_err_set", int'(err), 3'b010);
    chk("tmo_busy_idle", int'(busy), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_err_cleared", int'(err), 0);
    push_exp(1, 255);
    wkup_evt = 3'b010;
    tick();
    wkup_evt = 3'b000;
    repeat (254) tick();
    chk("tmo2_last_cycle_high", int'(pwr_d2_wkup), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo2_set_wins", int'(err), 3'b010);
    chk("tmo2_dropped", int'(pwr_d2_wkup), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo2_err_cleared", int'(err), 0);

    // Asynchronous reset during ASSERT, then re-request with event still high
    wkup_evt = 3'b100;
    tick();
    repeat (4) tick();
    chk("rstmid_high_before", int'(pwr_d3_wkup), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_wkup", int'(wkup_vec), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_err", int'(err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    lat[2] = 5;
    push_exp(2, 5);
    tick();
    chk("rstmid_rerequest", int'(pwr_d3_wkup), 1);
    wait_low(2, 20);
    wkup_evt = 3'b000;
    tick();
    chk("rstmid_busy_idle", int'(busy), 0);

    // All three domains at once with different ack latencies
    lat[0] = 6;
    lat[1] = 8;
    lat[2] = 20;
    push_exp(0, 6);
    push_exp(1, 8);
    push_exp(2, 20);
    wkup_evt = 3'b111;
    tick();
    chk("sim_rise", int'(wkup_vec), 3'b111);
    wait_low(2, 40);
    chk("sim_busy_release", int'(busy), 3'b111);
    chk("sim_err", int'(err), 0);
    wkup_evt = 3'b000;
    tick();
    chk("sim_busy_idle", int'(busy), 0);

    repeat (3) tick();
    chk("scoreboard_d1_empty", exp0.size(), 0);
    chk("scoreboard_d2_empty", exp1.size(), 0);
    chk("scoreboard_d3_empty", exp2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
